uart_bus_host: RTL and testbench

Synthesizable host-side controller for the UART's parallel CPU bus (C_nD, n_RD, n_WR, n_CS, DATA_IN/DATA_OUT). It stands in for the processor: it issues configuration-register writes, Tx-data writes, status-register reads and Rx-data reads with correct strobe timing. It also turns received bytes into a one-cycle valid pulse for on-chip logic. It connects directly to the UART's bus ports, which are mirrored here with opposite directions.

---
 rtl/uart_bus_host.sv | 157 +++++++++++++++
 tb/tb_uart_bus_host.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_bus_host.sv
// Host-side driver for the UART parallel CPU bus: config/Tx writes, status/Rx reads
// with programmable strobe width and recovery gap, all bus outputs registered.
module uart_bus_host #(
    parameter int STROBE_CYCLES   = 2,
    parameter int RECOVERY_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] cfg_word,
    input  logic       cfg_start,
    output logic       cfg_done,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       status_req,
    output logic [7:0] status,
    output logic       status_valid,
    output logic       busy,
    output logic       C_nD,
    output logic       n_RD,
    output logic       n_WR,
    output logic       n_CS,
    output logic [7:0] DATA_IN,
    input  logic [7:0] DATA_OUT,
    input  logic       Rx_RDY,
    input  logic       Tx_RDY
);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RECOVER} state_t;
    typedef enum logic [1:0] {OP_CFG, OP_STAT, OP_RX, OP_TX} op_t;

    localparam logic [3:0] STB = 4'(STROBE_CYCLES);
    localparam logic [3:0] REC = 4'(RECOVERY_CYCLES);

    state_t     r_state;
    op_t        r_op;
    logic [3:0] r_cnt;
    logic [7:0] r_wdata;
    logic       r_cfg_done, r_busy, r_cnd, r_rd_n, r_wr_n, r_cs_n;
    logic [7:0] r_din, r_rx_data, r_status;
    logic       r_rx_valid, r_status_valid;

    logic w_idle, w_tx_ready, w_is_write, w_is_cmd;

    assign w_idle     = (r_state == S_IDLE);
    assign w_tx_ready = w_idle && r_cfg_done && Tx_RDY && !cfg_start && !status_req && !Rx_RDY;
    assign w_is_write = (r_op == OP_CFG) || (r_op == OP_TX);
    assign w_is_cmd   = (r_op == OP_CFG) || (r_op == OP_STAT);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_op           <= OP_CFG;
            r_cnt          <= 4'd0;
            r_wdata        <= 8'h00;
            r_cfg_done     <= 1'b0;
            r_busy         <= 1'b0;
            r_cnd          <= 1'b1;
            r_rd_n         <= 1'b1;
            r_wr_n         <= 1'b1;
            r_cs_n         <= 1'b1;
            r_din          <= 8'h00;
            r_rx_data      <= 8'h00;
            r_status       <= 8'h00;
            r_rx_valid     <= 1'b0;
            r_status_valid <= 1'b0;
        end else begin
            r_rx_valid     <= 1'b0;
            r_status_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_cnt <= 4'd0;
                    if (cfg_start) begin
                        r_op    <= OP_CFG;
                        r_wdata <= cfg_word;
                        r_state <= S_ACCESS;
                    end else if (status_req) begin
                        r_op    <= OP_STAT;
                        r_state <= S_ACCESS;
                    end else if (Rx_RDY) begin
                        r_op    <= OP_RX;
                        r_state <= S_ACCESS;
                    end else if (tx_valid && w_tx_ready) begin
                        r_op    <= OP_TX;
                        r_wdata <= tx_data;
                        r_state <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    // count 0 is the setup cycle: the accepted request becomes bus state here
                    if (r_cnt == 4'd0) begin
                        r_cs_n <= 1'b0;
                        r_rd_n <= w_is_write;
                        r_wr_n <= !w_is_write;
                        r_cnd  <= w_is_cmd;
                        r_din  <= w_is_write ? r_wdata : 8'h00;
                        r_busy <= 1'b1;
                        r_cnt  <= 4'd1;
                    end else if (r_cnt == STB) begin
                        r_cs_n <= 1'b1;
                        r_rd_n <= 1'b1;
                        r_wr_n <= 1'b1;
                        if (r_op == OP_RX) begin
                            r_rx_data  <= DATA_OUT;
                            r_rx_valid <= 1'b1;
                        end
                        if (r_op == OP_STAT) begin
                            r_status       <= DATA_OUT;
                            r_status_valid <= 1'b1;
                        end
                        if (r_op == OP_CFG)
                            r_cfg_done <= 1'b1;
                        if (REC == 4'd0) begin
                            r_cnd   <= 1'b1;
                            r_din   <= 8'h00;
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end else begin
                            r_cnt   <= 4'd1;
                            r_state <= S_RECOVER;
                        end
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                S_RECOVER: begin
                    // C_nD/DATA_IN stay put here to give the UART address/data hold
                    if (r_cnt >= REC) begin
                        r_cnd   <= 1'b1;
                        r_din   <= 8'h00;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign cfg_done     = r_cfg_done;
    assign tx_ready     = w_tx_ready;
    assign rx_data      = r_rx_data;
    assign rx_valid     = r_rx_valid;
    assign status       = r_status;
    assign status_valid = r_status_valid;
    assign busy         = r_busy;
    assign C_nD         = r_cnd;
    assign n_RD         = r_rd_n;
    assign n_WR         = r_wr_n;
    assign n_CS         = r_cs_n;
    assign DATA_IN      = r_din;

endmodule

// File: tb/tb_uart_bus_host.sv
// Scoreboard bench for uart_bus_host: stimulus pushes expected bus accesses and read
// results; a negedge monitor pops and compares as the DUT presents them.
module tb_uart_bus_host;

    localparam int S = 2;
    localparam int R = 1;

    logic       clk = 0;
    logic       rst = 1;
    logic [7:0] cfg_word = 0, tx_data = 0, DATA_OUT = 0;
    logic       cfg_start = 0, tx_valid = 0, status_req = 0, Rx_RDY = 0, Tx_RDY = 0;
    logic       cfg_done, tx_ready, rx_valid, status_valid, busy;
    logic       C_nD, n_RD, n_WR, n_CS;
    logic [7:0] rx_data, status, DATA_IN;

    uart_bus_host #(.STROBE_CYCLES(S), .RECOVERY_CYCLES(R)) dut (
        .clk(clk), .rst(rst), .cfg_word(cfg_word), .cfg_start(cfg_start), .cfg_done(cfg_done),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .status_req(status_req), .status(status),
        .status_valid(status_valid), .busy(busy), .C_nD(C_nD), .n_RD(n_RD), .n_WR(n_WR),
        .n_CS(n_CS), .DATA_IN(DATA_IN), .DATA_OUT(DATA_OUT), .Rx_RDY(Rx_RDY), .Tx_RDY(Tx_RDY)
    );

    always #5 clk = ~clk;

    typedef struct {logic cnd; logic wr; logic [7:0] din;} bus_t;
    typedef struct {logic is_stat; logic [7:0] d;} rd_t;

    bus_t exp_bus[$];
    rd_t  exp_rd[$];
    int   total = 0;
    int   bad = 0;
    logic abort_exp = 0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endfunction

    // Monitor: bus accesses and read-result pulses
    logic cs_q = 1, rxv_q = 0, stv_q = 0, a_cnd = 1;
    logic [7:0] a_din = 0;
    int width = 0;
    always @(negedge clk) begin
        bus_t e;
        rd_t  r;
        if (!n_RD && !n_WR) chk("rd_wr_overlap", 1, 0);
        if (busy && tx_ready) chk("tx_ready_busy", 1, 0);
        if (!n_CS && cs_q) begin
            if (exp_bus.size() == 0) chk("unexpected_access", 1, 0);
            else begin
                e = exp_bus.pop_front();
                chk("acc_cnd", C_nD, e.cnd);
                chk("acc_nwr", n_WR, !e.wr);
                chk("acc_nrd", n_RD, e.wr);
                if (e.wr) chk("acc_din", DATA_IN, e.din);
            end
            a_cnd = C_nD;
            a_din = DATA_IN;
            width = 1;
        end else if (!n_CS) begin
            width++;
            if (C_nD !== a_cnd || DATA_IN !== a_din) chk("acc_stable", 1, 0);
        end else if (!cs_q && !abort_exp) begin
            chk("strobe_width", width, S);
            if (R > 0) begin
                chk("hold_cnd", C_nD, a_cnd);
                chk("hold_din", DATA_IN, a_din);
            end
        end
        cs_q = n_CS;
        if (rx_valid || status_valid) begin
            if (exp_rd.size() == 0) chk("unexpected_read_pulse", 1, 0);
            else begin
                r = exp_rd.pop_front();
                chk("rd_kind", status_valid, r.is_stat);
                chk("rd_data", r.is_stat ? status : rx_data, r.d);
            end
        end
        if ((rx_valid && rxv_q) || (status_valid && stv_q)) chk("valid_pulse_len", 1, 0);
        rxv_q = rx_valid;
        stv_q = status_valid;
    end

    // One request pulse from an idle host; kind 0=cfg 1=status 2=rx 3=tx
    task automatic do_req(input int kind, input logic [7:0] d);
        int n;
        bit done;
        @(negedge clk);
        case (kind)
            0: begin cfg_word = d; cfg_start = 1; exp_bus.push_back('{1'b1, 1'b1, d}); end
            1: begin status_req = 1; DATA_OUT = d;
                     exp_bus.push_back('{1'b1, 1'b0, 8'h00}); exp_rd.push_back('{1'b1, d}); end
            2: begin Rx_RDY = 1; DATA_OUT = d;
                     exp_bus.push_back('{1'b0, 1'b0, 8'h00}); exp_rd.push_back('{1'b0, d}); end
            default: begin tx_data = d; tx_valid = 1; exp_bus.push_back('{1'b0, 1'b1, d}); end
        endcase
        @(posedge clk);
        @(negedge clk);
        cfg_start = 0; status_req = 0; Rx_RDY = 0; tx_valid = 0;
        n = 0;
        done = 0;
        while (!done && n < 40) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (!busy && n >= 2) done = 1;
        end
        chk("busy_len", n, 1 + S + R);
        if (kind == 0) chk("cfg_done_set", cfg_done, 1);
    endtask

    initial begin
        int n;
        bit seen_tx;
        repeat (3) @(negedge clk);
        // Reset values
        chk("rst_cnd", C_nD, 1);
        chk("rst_strobes", {n_RD, n_WR, n_CS}, 3'b111);
        chk("rst_din", DATA_IN, 0);
        chk("rst_rx_data", rx_data, 0);
        chk("rst_status", status, 0);
        chk("rst_valids", {rx_valid, status_valid}, 0);
        chk("rst_cfg_done", cfg_done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_tx_ready", tx_ready, 0);
        rst = 0;
        Tx_RDY = 1;

        // Tx refused before configuration
        @(negedge clk);
        tx_data = 8'h68; tx_valid = 1;
        repeat (5) begin
            @(negedge clk);
            chk("tx_ready_precfg", tx_ready, 0);
            chk("ncs_precfg", n_CS, 1);
        end
        tx_valid = 0;

        do_req(0, 8'h14);
        do_req(3, 8'h68);
        do_req(2, 8'h68);
        do_req(1, 8'h05);

        // All four requests at once: cfg, then rx, then tx; status dropped
        @(negedge clk);
        cfg_word = 8'h3C; cfg_start = 1; status_req = 1; Rx_RDY = 1; DATA_OUT = 8'h9A;
        tx_data = 8'hE1; tx_valid = 1;
        exp_bus.push_back('{1'b1, 1'b1, 8'h3C});
        exp_bus.push_back('{1'b0, 1'b0, 8'h00});
        exp_bus.push_back('{1'b0, 1'b1, 8'hE1});
        exp_rd.push_back('{1'b0, 8'h9A});
        @(posedge clk);
        @(negedge clk);
        cfg_start = 0; status_req = 0;
        n = 0;
        seen_tx = 0;
        while (!seen_tx && n < 60) begin
            @(negedge clk);
            n++;
            if (!n_RD) Rx_RDY = 0;
            if (!n_WR && !C_nD) begin tx_valid = 0; seen_tx = 1; end
        end
        chk("prio_tx_seen", seen_tx, 1);
        n = 0;
        while (busy && n < 40) begin @(negedge clk); n++; end
        chk("prio_idle", busy, 0);

        // Randomised traffic
        for (int i = 0; i < 24; i++)
            do_req(int'($urandom_range(0, 3)), 8'($urandom));

        // Reset in the first strobe cycle of an Rx read
        @(negedge clk);
        abort_exp = 1;
        Rx_RDY = 1; DATA_OUT = 8'hA5;
        exp_bus.push_back('{1'b0, 1'b0, 8'h00});
        @(posedge clk);
        @(negedge clk);
        Rx_RDY = 0;
        @(negedge clk);
        chk("abort_strobe_low", n_RD, 0);
        rst = 1;
        @(negedge clk);
        chk("abort_strobes_high", {n_RD, n_WR, n_CS}, 3'b111);
        chk("abort_cfg_done", cfg_done, 0);
        chk("abort_busy", busy, 0);
        rst = 0;
        repeat (6) @(negedge clk);
        abort_exp = 0;

        chk("bus_queue_empty", exp_bus.size(), 0);
        chk("rd_queue_empty", exp_rd.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got 1 want 0");
        $fatal(1, "timeout");
    end

endmodule
